// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer.
// Accepts inst[31:7] plus an immediate-type code and presents the XLEN-wide immediate one cycle later.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [24:0]       inst_31_7,
    input  logic [2:0]        imm_type,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm,
    output logic [TAG_W-1:0]  tag_out,
    output logic              illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] TYPE_I     = 3'd0;
    localparam logic [2:0] TYPE_ISTAR = 3'd1;
    localparam logic [2:0] TYPE_S     = 3'd2;
    localparam logic [2:0] TYPE_B     = 3'd3;
    localparam logic [2:0] TYPE_U     = 3'd4;
    localparam logic [2:0] TYPE_J     = 3'd5;
    localparam logic [2:0] TYPE_Z     = 3'd6;

    // Index n of inst_31_7 is inst[n+7]; bit 24 is the sign bit inst[31].
    logic            sgn;
    logic [XLEN-1:0] imm_next;
    logic            illegal_next;

    assign sgn = inst_31_7[24];

    always_comb begin
        imm_next     = '0;
        illegal_next = 1'b0;
        case (imm_type)
            TYPE_I:     imm_next = {{(XLEN-12){sgn}}, inst_31_7[24:13]};
            TYPE_ISTAR: imm_next = (XLEN == 64) ? XLEN'(inst_31_7[18:13])
                                                : XLEN'(inst_31_7[17:13]);
            TYPE_S:     imm_next = {{(XLEN-12){sgn}}, inst_31_7[24:18], inst_31_7[4:0]};
            TYPE_B:     imm_next = {{(XLEN-12){sgn}}, inst_31_7[0], inst_31_7[23:18],
                                    inst_31_7[4:1], 1'b0};
            TYPE_U:     imm_next = {{(XLEN-31){sgn}}, inst_31_7[23:5], 12'b0};
            TYPE_J:     imm_next = {{(XLEN-20){sgn}}, inst_31_7[12:5], inst_31_7[13],
                                    inst_31_7[23:14], 1'b0};
            TYPE_Z:     imm_next = XLEN'(inst_31_7[12:8]);
            default:    illegal_next = 1'b1;
        endcase
    end

    // Handshake: a beat moves on any rising edge where valid && ready are both high.
    // in_ready depends only on the skid register, so no combinational path runs
    // from out_ready to in_ready.
    logic              out_valid_q;
    logic [XLEN-1:0]   out_imm_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_ill_q;
    logic              skid_valid_q;
    logic [XLEN-1:0]   skid_imm_q;
    logic [TAG_W-1:0]  skid_tag_q;
    logic              skid_ill_q;

    logic accept;
    logic out_free;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_imm_q    <= skid_imm_q;
                out_tag_q    <= skid_tag_q;
                out_ill_q    <= skid_ill_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= imm_next;
                out_tag_q   <= tag_in;
                out_ill_q   <= illegal_next;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            // OUT is stalled: park the new entry behind it.
            skid_valid_q <= 1'b1;
            skid_imm_q   <= imm_next;
            skid_tag_q   <= tag_in;
            skid_ill_q   <= illegal_next;
        end
    end

    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign tag_out   = out_tag_q;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are checked every cycle against an arithmetic immediate model and a 2-deep FIFO queue.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] inst_31_7;
    logic [2:0]  imm_type;
    logic [4:0]  tag_in;
    logic        out_ready;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    int errors;
    int n_checks;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .inst_31_7(inst_31_7), .imm_type(imm_type), .tag_in(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .tag_out(tag32), .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst_31_7(inst_31_7), .imm_type(imm_type), .tag_in(tag_in),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .tag_out(tag64), .illegal(ill64)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Immediate value from the field definitions using plain integer arithmetic.
    function automatic logic [63:0] model_imm(input logic [24:0] b, input logic [2:0] t,
                                              input int xlen);
        logic [31:0] i;
        logic        s;
        longint      v;
        i = {b, 7'b0};
        s = i[31];
        v = 0;
        case (t)
            3'd0: v = longint'(i[30:20]) - (s ? 64'sd2048 : 64'sd0);
            3'd1: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
            3'd2: v = longint'(i[30:25]) * 32 + longint'(i[11:7]) - (s ? 64'sd2048 : 64'sd0);
            3'd3: v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
                      - (s ? 64'sd4096 : 64'sd0);
            3'd4: v = longint'(i[30:12]) * 4096 - (s ? 64'sd2147483648 : 64'sd0);
            3'd5: v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                      + longint'(i[30:21]) * 2 - (s ? 64'sd1048576 : 64'sd0);
            3'd6: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    // Accepted entries {inst_31_7, imm_type, tag}; head is what OUT must show.
    logic [32:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            n = exp_q.size();
            if (n > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && n < 2) exp_q.push_back({inst_31_7, imm_type, tag_in});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [32:0] h;
        logic [63:0] e32;
        logic [63:0] e64;
        check("in_ready32", {63'b0, in_ready32}, {63'b0, exp_q.size() < 2});
        check("in_ready64", {63'b0, in_ready64}, {63'b0, exp_q.size() < 2});
        check("out_valid32", {63'b0, out_valid32}, {63'b0, exp_q.size() > 0});
        check("out_valid64", {63'b0, out_valid64}, {63'b0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            e32 = model_imm(h[32:8], h[7:5], 32);
            e64 = model_imm(h[32:8], h[7:5], 64);
            check("imm32", {32'h0, imm32}, e32);
            check("imm64", imm64, e64);
            check("tag32", {59'b0, tag32}, {59'b0, h[4:0]});
            check("tag64", {59'b0, tag64}, {59'b0, h[4:0]});
            check("illegal32", {63'b0, ill32}, {63'b0, h[7:5] == 3'd7});
            check("illegal64", {63'b0, ill64}, {63'b0, h[7:5] == 3'd7});
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic v, input logic [24:0] bits, input logic [2:0] t,
                       input logic [4:0] tg, input logic ordy, input logic fl);
        in_valid  = v;
        inst_31_7 = bits;
        imm_type  = t;
        tag_in    = tg;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_out_valid32"}, {63'b0, out_valid32}, 64'd0);
        check({where, "_in_ready32"},  {63'b0, in_ready32},  64'd1);
        check({where, "_imm32"},       {32'h0, imm32},       64'd0);
        check({where, "_tag32"},       {59'b0, tag32},       64'd0);
        check({where, "_illegal32"},   {63'b0, ill32},       64'd0);
        check({where, "_out_valid64"}, {63'b0, out_valid64}, 64'd0);
        check({where, "_in_ready64"},  {63'b0, in_ready64},  64'd1);
        check({where, "_imm64"},       imm64,                64'd0);
    endtask

    localparam logic [24:0] ADDI_M1 = 25'h1FFE001;
    localparam logic [24:0] LUI     = 25'h02468A1;

    logic [24:0] sweep_tab [6];

    initial begin
        errors    = 0;
        n_checks  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst_31_7 = '0;
        imm_type  = '0;
        tag_in    = '0;
        out_ready = 1'b1;
        sweep_tab[0] = 25'h1FFE001;
        sweep_tab[1] = 25'h02468A1;
        sweep_tab[2] = 25'h0A5A5A5;
        sweep_tab[3] = 25'h1555555;
        sweep_tab[4] = 25'h1FFFFFF;
        sweep_tab[5] = 25'h0000001;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // addi x1,x0,-1 as I-type
        cyc(1, ADDI_M1, 3'd0, 5'd3, 1, 0);
        check("addi_valid", {63'b0, out_valid32}, 64'd1);
        check("addi_imm32", {32'h0, imm32}, 64'h0000_0000_FFFF_FFFF);
        check("addi_tag", {59'b0, tag32}, 64'd3);
        check("addi_ill", {63'b0, ill32}, 64'd0);
        cyc(0, '0, 3'd0, 5'd0, 1, 0);

        // back-to-back U, Z, NONE
        cyc(1, LUI, 3'd4, 5'd4, 1, 0);
        check("lui_imm32", {32'h0, imm32}, 64'h0000_0000_1234_5000);
        check("lui_imm64", imm64, 64'h0000_0000_1234_5000);
        cyc(1, LUI, 3'd6, 5'd5, 1, 0);
        check("z_imm32", {32'h0, imm32}, 64'h8);
        check("z_tag", {59'b0, tag32}, 64'd5);
        cyc(1, LUI, 3'd7, 5'd6, 1, 0);
        check("none_imm32", {32'h0, imm32}, 64'h0);
        check("none_ill", {63'b0, ill32}, 64'd1);
        cyc(0, '0, 3'd0, 5'd0, 1, 0);

        // XLEN=64 U and ISTAR
        cyc(1, ADDI_M1, 3'd4, 5'd1, 1, 0);
        check("u64_imm", imm64, 64'hFFFF_FFFF_FFF0_0000);
        check("u32_imm", {32'h0, imm32}, 64'h0000_0000_FFF0_0000);
        cyc(1, ADDI_M1, 3'd1, 5'd2, 1, 0);
        check("istar64_imm", imm64, 64'h3F);
        check("istar32_imm", {32'h0, imm32}, 64'h1F);

        // B/J/S sign and single-bit placement
        cyc(1, 25'h1FFFFFF, 3'd3, 5'd7, 1, 0);
        check("b_ones", imm64, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc(1, 25'h1FFFFFF, 3'd5, 5'd8, 1, 0);
        check("j_ones", {32'h0, imm32}, 64'hFFFF_FFFE);
        cyc(1, 25'h1FFFFFF, 3'd2, 5'd9, 1, 0);
        check("s_ones", {32'h0, imm32}, 64'hFFFF_FFFF);
        cyc(1, 25'h0000001, 3'd3, 5'd10, 1, 0);
        check("b_bit11", {32'h0, imm32}, 64'h800);
        cyc(1, 25'h0002000, 3'd5, 5'd11, 1, 0);
        check("j_bit11", imm64, 64'h800);
        cyc(0, '0, 3'd0, 5'd0, 1, 0);

        // backpressure: tags 1,2 accepted, 3 held off
        cyc(1, LUI, 3'd0, 5'd1, 0, 0);
        cyc(1, LUI, 3'd2, 5'd2, 0, 0);
        check("bp_in_ready0", {63'b0, in_ready32}, 64'd0);
        check("bp_hold_tag1", {59'b0, tag32}, 64'd1);
        cyc(1, LUI, 3'd3, 5'd3, 0, 0);
        cyc(1, LUI, 3'd3, 5'd3, 0, 0);
        check("bp_still_tag1", {59'b0, tag32}, 64'd1);
        cyc(1, LUI, 3'd3, 5'd3, 1, 0);
        check("bp_tag2", {59'b0, tag32}, 64'd2);
        cyc(1, LUI, 3'd3, 5'd3, 1, 0);
        check("bp_tag3", {59'b0, tag32}, 64'd3);
        cyc(0, '0, 3'd0, 5'd0, 1, 0);
        check("bp_drained", {63'b0, out_valid32}, 64'd0);

        // flush with both full, then flush discarding a same-cycle accept
        cyc(1, LUI, 3'd4, 5'd4, 0, 0);
        cyc(1, LUI, 3'd5, 5'd5, 0, 0);
        cyc(1, LUI, 3'd6, 5'd6, 0, 1);
        check("flush_out_valid", {63'b0, out_valid32}, 64'd0);
        check("flush_in_ready", {63'b0, in_ready64}, 64'd1);
        cyc(1, LUI, 3'd0, 5'd7, 0, 0);
        check("post_flush_tag", {59'b0, tag64}, 64'd7);
        cyc(1, LUI, 3'd1, 5'd8, 0, 1);
        check("flush_drop_accept", {63'b0, out_valid64}, 64'd0);
        cyc(0, '0, 3'd0, 5'd0, 1, 0);
        cyc(0, '0, 3'd0, 5'd0, 1, 0);
        check("no_stale", {63'b0, out_valid32}, 64'd0);

        // asynchronous reset mid-stall with both entries full
        cyc(1, ADDI_M1, 3'd0, 5'd9, 0, 0);
        cyc(1, ADDI_M1, 3'd4, 5'd10, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cyc(1, LUI, 3'd4, 5'd11, 1, 0);
        check("after_reset_imm", {32'h0, imm32}, 64'h1234_5000);
        check("after_reset_valid", {63'b0, out_valid64}, 64'd1);

        // sweep every type over a few patterns with irregular valid/ready
        for (int i = 0; i < 48; i++) begin
            cyc((i % 5) != 4, sweep_tab[i % 6], 3'(i % 8), 5'(i), (i % 3) != 2, 0);
        end
        for (int i = 0; i < 4; i++) cyc(0, '0, 3'd0, 5'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the stage1 decode path. It accepts the instruction's upper 25 bits and an immediate-type code through a valid/ready handshake, and produces the extended immediate one cycle later. A 2-entry skid buffer lets stage2 stall without combinational ready paths. Compared with the combinational generator, it adds XLEN=64 support, a CSR zero-extended immediate (Z-type), an illegal-type flag, tag passthrough and flush.

Parameters:
XLEN, 32, immediate output width; only 32 or 64 are legal (anything else is an elaboration error).
TAG_W, 5, width of the opaque sideband tag carried alongside each immediate (e.g. rd or ROB index).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous; drops all buffered entries.
in_valid  input  1  input entry valid.
in_ready  output  1  block can accept an input entry; driven only from registers.
inst_31_7  input  25  instruction bits [31:7]; index n corresponds to inst[n+7].
imm_type  input  3  0=I, 1=ISTAR, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR uimm), 7=NONE.
tag_in  input  TAG_W  sideband tag.
out_valid  output  1  output entry valid.
out_ready  input  1  consumer accepts the output entry.
imm  output  XLEN  generated immediate.
tag_out  output  TAG_W  tag paired with imm.
illegal  output  1  entry had imm_type NONE (7).

Behaviour:
- Formation (combinational, before the register), all fields are XLEN bits; s = inst[31]:
  - I = sext(inst[31:20]).
  - ISTAR = zext(inst[24:20]) when XLEN=32; zext(inst[25:20]) when XLEN=64.
  - S = sext({inst[31:25], inst[11:7]}).
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U = sext({inst[31:12], 12'b0}); upper 32 bits are copies of s when XLEN=64.
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Z = zext(inst[19:15]).
  - NONE: imm = 0 and illegal = 1. No X is ever driven.
- Storage: output register (OUT) plus skid register (SKID), each holding {valid, imm, tag, illegal}.
- Handshakes:
  - in_ready = !SKID.valid.
  - An input is accepted when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 if OUT is empty or transferring in cycle N.
- Per-cycle update:
  - OUT empty or transferring, SKID empty: an accepted input loads OUT; otherwise OUT.valid clears.
  - OUT empty or transferring, SKID full: SKID moves to OUT and SKID clears. in_ready was 0 this cycle, so nothing was accepted.
  - OUT full and stalled: an accepted input loads SKID.
- Ordering: entries are strictly FIFO and never dropped or duplicated. Throughput is 1 entry/cycle when out_ready=1.
- flush: clears OUT.valid and SKID.valid next edge; any input accepted in the same cycle is discarded; flush has priority over all other updates.
- Reset (rst_n=0, any time, including mid-transfer): OUT.valid=0, SKID.valid=0, so out_valid=0 and in_ready=1; imm=0, tag_out=0, illegal=0. Outputs take these values immediately, without waiting for a clock edge.
- Data registers load only on accept, so imm, tag_out and illegal hold stable while out_valid && !out_ready.

Test Plan:
- Reset then XLEN=32, out_ready=1: inst_31_7=0x1FFE001 (addi x1,x0,-1), type I, tag 3 -> next cycle out_valid=1, imm=0xFFFFFFFF, tag_out=3, illegal=0.
- XLEN=32, back-to-back over 3 cycles:
  - inst_31_7=0x2468A1 (lui 0x12345) type U -> imm=0x12345000.
  - Same bits type Z -> imm=0x00000008 (inst[19:15]=0x08).
  - Type 7 -> imm=0, illegal=1.
  - Expect three consecutive output cycles in order.
- XLEN=64, inst_31_7=0x1FFE001 type U -> imm=0xFFFFFFFFFFF00000; same bits type ISTAR -> imm=0x3F.
- Backpressure: out_ready=0, push tags 1,2,3 on consecutive cycles -> tags 1,2 accepted, in_ready=0 from the cycle after tag 2 is accepted, tag 3 held off. Then raise out_ready -> outputs 1,2,3 in order with no loss; imm/tag_out stable while stalled.
- With OUT and SKID both full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; no stale entry appears afterwards.
- Drop rst_n asynchronously mid-stall with both entries full -> out_valid=0, in_ready=1 before the next edge; normal operation after release.
